fifo_deserializer: RTL

Upstream feeder for the accelerator's `fifo`. It accepts a stream of narrow `DATA_WIDTH` words over a valid/ready handshake and packs `COUNT` consecutive words into one wide word. It then writes that word into the downstream fifo using the fifo's `enq`/`full_n` protocol and holds it under backpressure. Input bandwidth stays at one narrow word per cycle, with no bubbles between wide words.

---
 rtl/fifo_deserializer_pkg.sv | 13 +
 rtl/slot_counter.sv | 24 ++
 rtl/fifo_deserializer.sv | 78 +++++++
 3 files changed

// File: rtl/fifo_deserializer_pkg.sv
// Shared types and default sizing for the fifo deserializer slice.
package fifo_deserializer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_COUNT      = 3;
  localparam int OUT_WIDTH          = DEFAULT_COUNT * DEFAULT_DATA_WIDTH;

endpackage

// File: rtl/slot_counter.sv
// Modulo-COUNT slot counter with enable, synchronous clear and a last-slot flag.
module slot_counter #(
  parameter int COUNT = 3,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  assign last = (count == WIDTH'(COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_deserializer.sv
// Packs COUNT narrow words into one wide word and enqueues it into a downstream fifo.
module fifo_deserializer
  import fifo_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int COUNT         = DEFAULT_COUNT,
  parameter int COUNTER_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [COUNT*DATA_WIDTH-1:0]   out_data,
  output logic                          enq,
  input  logic                          full_n
);

  state_t                   state;
  state_t                   state_next;
  logic                     accept;
  logic                     last;
  logic [COUNTER_WIDTH-1:0] count;

  slot_counter #(
    .COUNT (COUNT),
    .WIDTH (COUNTER_WIDTH)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (accept),
    .count (count),
    .last  (last)
  );

  // In HOLD a new word may only enter when the fifo drains the held one this edge.
  always_comb begin
    in_ready   = 1'b0;
    state_next = state;
    if (!rst && !clr) begin
      in_ready = (state == FILL) || full_n;
    end
    accept = in_valid && in_ready;
    if (rst || clr) begin
      state_next = FILL;
    end else if (accept && last) begin
      state_next = HOLD;
    end else if (state == HOLD && full_n) begin
      state_next = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  assign enq = (state == HOLD);

  // Slots double as the output register; they are never cleared between words.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (accept) begin
      for (int i = 0; i < COUNT; i++) begin
        if (count == COUNTER_WIDTH'(i)) begin
          out_data[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        end
      end
    end
  end

endmodule
